// File: rtl/uart_tx_fifo_reader.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_reader
//
// Serial UART transmitter that drains a first-word-fall-through FIFO. Each
// FIFO word is sent as one frame: a start bit (low), DATA_BITS data bits LSB
// first, and a stop bit (high). Every bit lasts CLKS_PER_BIT clocks.
//
// The head word is captured on the same edge that starts the frame. fifo_pop
// is raised for that first start-bit cycle only, so the FIFO read pointer
// moves after the word is already held in the shift register.
//
// Parameters:
//   DATA_BITS     word width and data bits per frame (5..9)
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   fifo_empty  FIFO holds no words
//   fifo_data   FIFO head word, valid while fifo_empty is low
//   fifo_pop    one-cycle pulse, FIFO advances its read pointer
//   tx          serial line, idle high, driven straight from a flop
//   busy        high while a frame is in flight (START/DATA/STOP)
//   done        one-cycle pulse in the IDLE cycle after the stop bit
// ---------------------------------------------------------------------------
module uart_tx_fifo_reader #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_pop,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // Elaboration-time parameter guards.
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx_fifo_reader: CLKS_PER_BIT must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
            $error("uart_tx_fifo_reader: DATA_BITS must be in 5..9");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;

    // Last cycle of the current serial bit.
    logic bit_end;
    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            fifo_pop <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            // Both strobes are single-cycle pulses.
            fifo_pop <= 1'b0;
            done     <= 1'b0;

            // Free-running bit timer while a frame is in flight.
            if (state != IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);
            end

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        // Capture and pop together; the pop is seen by the
                        // FIFO after the word is already held here.
                        shift    <= fifo_data;
                        fifo_pop <= 1'b1;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        tx    <= shift[0];
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // tx takes the bit that becomes shift[0] next.
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
- Serial UART transmitter that drains a first-word-fall-through FIFO: it sees the head word on `fifo_data` whenever `fifo_empty` is low, and it advances the FIFO with a one-cycle `fifo_pop`.
- Each word is sent as 8N1-style frames: one start bit, DATA_BITS data bits LSB first, one stop bit.
- Sits between the UART TX FIFO and the board TX pin. It is the consumer for the FIFO's push/ack producer side.

Parameters:
- DATA_BITS, 8, word width and number of data bits per frame (range 5..9).
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200). Must be >= 2; elaborate-time error otherwise.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- fifo_empty  input  1  high when the FIFO holds no words.
- fifo_data  input  DATA_BITS  FIFO head word; valid whenever fifo_empty=0.
- fifo_pop  output  1  one-cycle pulse; FIFO advances its read pointer on it.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in flight (START/DATA/STOP).
- done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset: one clock is the only clock. Reset is synchronous and active-high. On a clk edge with reset=1:
  - state=IDLE; tx=1; fifo_pop=0; busy=0; done=0.
  - baud_cnt=0; bit_cnt=0; shift register=0.
- All outputs are registered.
- Counter widths: baud_cnt is $clog2(CLKS_PER_BIT) bits; bit_cnt is $clog2(DATA_BITS) bits.
- FSM states are IDLE, START, DATA and STOP.
- IDLE:
  - done<=0 by default.
  - If fifo_empty=0 at an edge: latch fifo_data into the shift register, fifo_pop<=1, tx<=0, busy<=1, baud_cnt<=0, bit_cnt<=0, state<=START.
  - If fifo_empty=1: remain idle, tx=1.
- fifo_pop:
  - Deasserted at the next edge, so it is high for exactly one cycle per frame.
  - It is high during the first start-bit cycle, after the data is already captured. The FIFO pointer therefore moves after capture, with no double read.
- Bit timer: in START, DATA and STOP, baud_cnt increments each cycle. At baud_cnt==CLKS_PER_BIT-1 it wraps to 0 and the bit-end action fires. Every bit therefore lasts exactly CLKS_PER_BIT cycles.
- START bit-end: tx<=shift[0], state<=DATA.
- DATA bit-end:
  - If bit_cnt==DATA_BITS-1: tx<=1, state<=STOP.
  - Otherwise: shift right by one, tx<=next bit, bit_cnt++.
- STOP bit-end: state<=IDLE, busy<=0, done<=1.
- Frame timing:
  - Frame length: (DATA_BITS+2)*CLKS_PER_BIT cycles from the first tx-low cycle to the done-high cycle.
  - The done-high cycle is an IDLE cycle. A new frame can begin at that cycle's ending edge.
  - Back-to-back start-bit spacing is (DATA_BITS+2)*CLKS_PER_BIT+1 cycles.
- fifo_empty and fifo_data are ignored outside IDLE. A word is never popped while fifo_empty=1 at the sampling edge.
- Reset mid-frame: the frame is abandoned and tx returns high on the next edge. The popped word is lost, done is not pulsed, and no extra pop occurs.
- Simultaneous reset and fifo_empty=0: reset wins, so no pop and no capture.
- tx is glitch-free because it is driven straight from a flop.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8):
- Reset held 5 cycles, fifo_empty=1, then released for 20 cycles -> tx=1, fifo_pop=0, busy=0, done=0 throughout.
- FIFO presents 0xA5 then goes empty after the pop -> expected response:
  - exactly one fifo_pop cycle;
  - tx carries 0,1,0,1,0,0,1,0,1,1, each held 4 cycles;
  - busy high 40 cycles;
  - done pulses 1 cycle, 40 cycles after tx first falls.
- FIFO holds 0x00 then 0xFF -> expected response:
  - two pops, 41 cycles apart;
  - tx falls 41 cycles apart;
  - between the frames tx is high for 5 cycles (stop bit plus one idle cycle);
  - the second frame's data bits are all 1.
- Start 0x3C, assert reset on cycle 15 of the frame for 1 cycle with the FIFO then empty -> tx=1 and busy=0 from the next edge, no done, no further pops, line stays idle.
- Toggle fifo_empty and change fifo_data every cycle during a frame of 0x81 -> transmitted bits remain 1,0,0,0,0,0,0,1 (LSB first), and only one pop per frame.
